// File: rtl/aes_dec_pkg.sv
// Shared constants and types for the AES decryptor output path.
package aes_dec_pkg;

  localparam int AES_BLK_W   = 128;
  localparam int DEC_LATENCY = 20;
  localparam int OUT_DEPTH   = 32;
  localparam int BLK_IDX_W   = 8;

  // One buffered plaintext block as it travels through the output FIFO.
  typedef struct packed {
    logic [AES_BLK_W-1:0] data;
    logic [BLK_IDX_W-1:0] idx;
    logic                 last;
  } dec_entry_t;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/aes_dec_out_buffer_if.sv
// Source-side and consumer-side handshake of the decryptor output buffer.
// master: the buffer itself; slave: the surrounding source/consumer.
interface aes_dec_out_buffer_if
  import aes_dec_pkg::*;
#(
  parameter int DATA_W = AES_BLK_W,
  parameter int IDX_W  = BLK_IDX_W,
  parameter int LVL_W  = level_w(OUT_DEPTH)
);

  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [DATA_W-1:0] plaintext;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic [LVL_W-1:0]  level;
  logic              err_ovf;

  modport master (
    input  in_valid, in_last, plaintext, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, level, err_ovf
  );

  modport slave (
    output in_valid, in_last, plaintext, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, level, err_ovf
  );

endinterface

// File: rtl/aes_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy output and a sticky overflow flag.
// A push while full is accepted only if a pop frees the head slot in the same cycle.
module aes_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic [LVL_W-1:0] level,
  output logic             ovf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             pop_en;
  logic             wr_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (level == LVL_W'(DEPTH));
  assign empty  = (level == '0);
  assign pop_en = pop & ~empty;
  assign wr_en  = push & (~full | pop_en);
  assign valid  = ~empty;
  assign dout   = empty ? '0 : mem[rd_ptr];

  // Storage array: written on every accepted push.
  // NOTE: the data array has no reset; occupancy is tracked by level and the
  // head is masked to zero while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en)  wr_ptr <= ptr_inc(wr_ptr);
      if (pop_en) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_en && !pop_en)      level <= level + 1'b1;
      else if (pop_en && !wr_en) level <= level - 1'b1;
      if (push && full && !pop_en) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/aes_dec_out_buffer.sv
// Output buffer for the fixed-latency pipelined AES-128 decryptor.
// A delay line marks which decryptor output cycles carry accepted blocks; only
// those are captured into the FIFO, tagged with a running index and last flag.
// Credits (in flight + buffered) throttle the source so the FIFO cannot overflow.
module aes_dec_out_buffer
  import aes_dec_pkg::*;
#(
  parameter int DATA_W  = AES_BLK_W,
  parameter int LATENCY = DEC_LATENCY,
  parameter int DEPTH   = OUT_DEPTH,
  parameter int IDX_W   = BLK_IDX_W
) (
  input logic                  clk,
  input logic                  rst,
  aes_dec_out_buffer_if.master bus
);

  localparam int LVL_W = level_w(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int SUM_W = LVL_W + 1;
  localparam int ENT_W = DATA_W + IDX_W + 1;

  logic               accept;
  logic               capture;
  logic               pop;
  logic [LATENCY-1:0] dl_valid;
  logic [LATENCY-1:0] dl_last;
  logic [CNT_W-1:0]   inflight;
  logic [IDX_W-1:0]   idx_cnt;
  logic [LVL_W-1:0]   level;
  logic [ENT_W-1:0]   push_word;
  logic [ENT_W-1:0]   head_word;

  assign accept  = bus.in_valid & bus.in_ready;
  assign capture = dl_valid[LATENCY-1];
  assign pop     = bus.out_valid & bus.out_ready;

  // Credit check uses registered state only, so the source never sees a
  // combinational path from its own in_valid back to in_ready.
  assign bus.in_ready = (SUM_W'(inflight) + SUM_W'(level)) < SUM_W'(DEPTH);

  // Delay line: the last stage is high exactly while plaintext holds a tracked block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dl_valid <= '0;
      dl_last  <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage read its neighbour's
      // pre-edge value, so the loop order does not matter.
      dl_valid[0] <= accept;
      dl_last[0]  <= accept & bus.in_last;
      for (int i = 1; i < LATENCY; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_last[i]  <= dl_last[i-1];
      end
    end
  end

  // In-flight block count and capture-order index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= '0;
      idx_cnt  <= '0;
    end else begin
      if (accept && !capture)      inflight <= inflight + 1'b1;
      else if (capture && !accept) inflight <= inflight - 1'b1;
      if (capture) idx_cnt <= idx_cnt + 1'b1;
    end
  end

  assign push_word = {bus.plaintext, idx_cnt, dl_last[LATENCY-1]};

  aes_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .din   (push_word),
    .pop   (pop),
    .dout  (head_word),
    .valid (bus.out_valid),
    .level (level),
    .ovf   (bus.err_ovf)
  );

  assign {bus.out_data, bus.out_idx, bus.out_last} = head_word;
  assign bus.level = level;

endmodule

// File: tb/tb_aes_dec_out_buffer.sv
// Self-checking bench for aes_dec_out_buffer. A stand-in decryptor (fixed
// XOR with a key through an unstallable pipeline) feeds plaintext; a queue
// model of accepted-but-not-consumed blocks predicts every output each cycle.
module tb_aes_dec_out_buffer;
  import aes_dec_pkg::*;

  localparam int L = DEC_LATENCY;
  localparam int D = OUT_DEPTH;
  localparam logic [127:0] KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] W0  = 128'h54686500636f6d706c65786974790066;
  localparam logic [127:0] W23 = 128'h61770000000000000000000000000000;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] ct  = '0;
  logic [127:0] pipe [L];
  bit           rand_ready = 1'b0;

  aes_dec_out_buffer_if #(
    .DATA_W (AES_BLK_W),
    .IDX_W  (BLK_IDX_W),
    .LVL_W  (level_w(OUT_DEPTH))
  ) bus ();

  aes_dec_out_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stand-in decryptor: never stalls, processes whatever is on ct every cycle.
  always @(posedge clk) begin
    pipe[0] <= ct ^ KEY;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.plaintext = pipe[L-1];

  // Random consumer backpressure when enabled.
  always @(posedge clk) begin
    #2;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- reference model ----------------
  typedef struct {int t; dec_entry_t e;} item_t;
  typedef struct {int cyc; dec_entry_t e;} log_t;

  item_t       q[$];       // accepted, not yet consumed
  log_t        popped[$];  // consumed words of the current test
  int          cyc = 0;    // number of the most recent clock edge
  logic [7:0]  idx_n = '0;
  int          acc_cnt = 0;
  int          first_acc = -1;
  int          first_valid = -1;

  // A block accepted at edge t is visible from edge t+L onward; everything
  // accepted and not yet consumed holds one credit.
  always @(negedge clk) begin : compare
    int         lvl;
    bit         ev;
    item_t      it;
    dec_entry_t head;
    if (!rst) begin
      q.delete();
      idx_n = '0;
    end
    lvl = 0;
    foreach (q[i]) if (q[i].t + L <= cyc) lvl++;
    ev = (q.size() > 0) && (q[0].t + L <= cyc);
    check("out_valid", 128'(bus.out_valid), 128'(ev));
    check("level", 128'(bus.level), 128'(lvl));
    check("in_ready", 128'(bus.in_ready), 128'(q.size() < D));
    check("err_ovf", 128'(bus.err_ovf), 128'(0));
    if (ev) begin
      head = q[0].e;
      check("out_data", bus.out_data, head.data);
      check("out_idx", 128'(bus.out_idx), 128'(head.idx));
      check("out_last", 128'(bus.out_last), 128'(head.last));
      if (first_valid < 0) first_valid = cyc;
    end else if (!rst) begin
      check("rst_out_data", bus.out_data, '0);
      check("rst_out_idx", 128'(bus.out_idx), '0);
      check("rst_out_last", 128'(bus.out_last), '0);
    end
    cyc++;
    if (rst) begin
      if (bus.in_valid && bus.in_ready) begin
        it.t      = cyc;
        it.e.data = ct ^ KEY;
        it.e.idx  = idx_n;
        it.e.last = bus.in_last;
        q.push_back(it);
        idx_n++;
        acc_cnt++;
        if (first_acc < 0) first_acc = cyc;
      end
      if (bus.out_valid && bus.out_ready && q.size() > 0) begin
        popped.push_back('{cyc: cyc, e: q[0].e});
        void'(q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      ct = rand128();
      tick();
    end
  endtask

  // Present one block and hold it until the buffer accepts it.
  task automatic send(input logic [127:0] pt, input logic last);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    ct = pt ^ KEY;
    while (!got && n < 200) begin
      @(negedge clk);
      got = bus.in_ready;
      tick();
      n++;
    end
    if (!got) fail_now("send_timeout");
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    ct = rand128();
  endtask

  task automatic wait_drained(input int bound);
    int n;
    n = 0;
    while (q.size() > 0 && n < bound) begin
      idle(1);
      n++;
    end
    if (q.size() > 0) fail_now("drain_timeout");
  endtask

  // ---------------- tests ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    ct = rand128();

    // 1: reset state, then release with no traffic.
    repeat (3) tick();
    check("t1_in_ready", 128'(bus.in_ready), 128'(1));
    check("t1_out_valid", 128'(bus.out_valid), 128'(0));
    check("t1_level", 128'(bus.level), 128'(0));
    rst = 1'b1;
    idle(5);
    check("t1_idle_valid", 128'(bus.out_valid), 128'(0));
    check("t1_idle_ready", 128'(bus.in_ready), 128'(1));

    // 2: 24 blocks back-to-back with a free-running consumer.
    popped.delete();
    first_acc = -1;
    first_valid = -1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 24; i++)
      send((i == 0) ? W0 : (i == 23) ? W23 : rand128(), 1'(i == 23));
    wait_drained(100);
    check("t2_count", 128'(popped.size()), 128'(24));
    // accept edge counts as edge 1, so out_valid after edge 21 is 20 edges later
    check("t2_latency", 128'(first_valid - first_acc), 128'(20));
    if (popped.size() == 24) begin
      check("t2_w0_data", popped[0].e.data, W0);
      check("t2_w0_idx", 128'(popped[0].e.idx), 128'(0));
      check("t2_w23_data", popped[23].e.data, W23);
      check("t2_w23_idx", 128'(popped[23].e.idx), 128'(23));
      check("t2_w23_last", 128'(popped[23].e.last), 128'(1));
      check("t2_no_gaps", 128'(popped[23].cyc - popped[0].cyc), 128'(23));
    end

    // 3: consumer stalled, source always valid: credits stop it at 32.
    popped.delete();
    acc_cnt = 0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    idle(60);
    check("t3_accepts", 128'(acc_cnt), 128'(32));
    check("t3_level", 128'(bus.level), 128'(32));
    check("t3_in_ready", 128'(bus.in_ready), 128'(0));

    // 4: free one slot, refill it, then pop exactly on the refill's capture edge.
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check("t4_refill_accepts", 128'(acc_cnt), 128'(33));
    idle(L - 1);
    check("t4_level_before", 128'(bus.level), 128'(31));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("t4_level_after", 128'(bus.level), 128'(31));
    bus.out_ready = 1'b1;
    wait_drained(100);
    check("t4_drained", 128'(popped.size()), 128'(33));
    if (popped.size() == 33) begin
      check("t4_first_idx", 128'(popped[0].e.idx), 128'(24));
      check("t4_final_idx", 128'(popped[32].e.idx), 128'(56));
    end

    // 5: reset with 5 blocks buffered and 5 still in the decryptor.
    popped.delete();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) send(rand128(), 1'b0);
    idle(15);
    check("t5_pre_valid", 128'(bus.out_valid), 128'(1));
    check("t5_pre_level", 128'(bus.level), 128'(5));
    rst = 1'b0;
    #1;
    check("t5_rst_valid", 128'(bus.out_valid), 128'(0));
    check("t5_rst_level", 128'(bus.level), 128'(0));
    idle(2);
    rst = 1'b1;
    idle(30);
    check("t5_stale_ignored", 128'(bus.out_valid), 128'(0));
    bus.out_ready = 1'b1;
    send(rand128(), 1'b1);
    wait_drained(100);
    check("t5_count", 128'(popped.size()), 128'(1));
    if (popped.size() == 1) begin
      check("t5_idx", 128'(popped[0].e.idx), 128'(0));
      check("t5_last", 128'(popped[0].e.last), 128'(1));
    end

    // 6: sparse source, random consumer.
    popped.delete();
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(rand128(), 1'(i == 39));
      idle(2);
    end
    tick();
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
    wait_drained(200);
    check("t6_count", 128'(popped.size()), 128'(40));
    if (popped.size() == 40) begin
      check("t6_first_idx", 128'(popped[0].e.idx), 128'(1));
      for (int i = 1; i < 40; i++)
        check("t6_idx_contig", 128'(popped[i].e.idx), 128'(8'(popped[0].e.idx + 8'(i))));
      check("t6_last", 128'(popped[39].e.last), 128'(1));
    end

    idle(3);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
